instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
Fetch stage that sits directly upstream of the 32-word instruction memory (mem_instr). Holds the program counter and drives the 5-bit word address into the memory. Captures the returned 32-bit instruction into an IF/ID pipeline register for decode. Supports stall, branch/jump redirect with bubble insertion, and misaligned-target detection.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset; must be word aligned.
IM_ADDR_W, 5, width of the instruction-memory word address.
NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0).

Ports:
clk  in  1  single system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
stall  in  1  hazard stall from decode; holds PC and IF/ID.
pc_src  in  1  redirect request (taken branch or jump) from execute.
pc_target  in  32  redirect target address.
im_address  out  IM_ADDR_W  word address to mem_instr.
im_rd  in  32  instruction word returned combinationally by mem_instr.
pc_f  out  32  current fetch PC.
instr_d  out  32  IF/ID instruction.
pc_d  out  32  IF/ID PC of instr_d.
pc_plus4_d  out  32  IF/ID pc_d+4.
valid_d  out  1  IF/ID holds a real instruction (0 = bubble).
misaligned  out  1  sticky flag: redirect target had nonzero bits [1:0].

Behaviour:
- Reset (async, active-high): reset is an asynchronous, active-high input on the single clock clk. While asserted, all registers take their reset values immediately, independent of clk. Reset values: pc_f=RESET_PC, instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, valid_d=0, misaligned=0. Reset asserted mid-operation discards everything in flight; no state survives.
- im_address = pc_f[IM_ADDR_W+1:2], combinational. Bits [1:0] and the bits above IM_ADDR_W+1 are ignored, so memory indexing wraps every 2^IM_ADDR_W words. PC 0x7C+4=0x80 gives im_address 0.
- Next PC at each rising edge, in priority order:
  1. pc_src=1: pc_f <= {pc_target[31:2],2'b00}. Redirect overrides stall.
  2. stall=1: pc_f holds.
  3. Otherwise: pc_f <= pc_f+4, modulo 2^32 (0xFFFFFFFC -> 0x00000000).
- IF/ID register at each rising edge, same priority:
  1. pc_src=1 (flush): instr_d<=NOP_INSTR, valid_d<=0, pc_d<=0, pc_plus4_d<=0.
  2. stall=1: all IF/ID outputs hold.
  3. Otherwise: instr_d<=im_rd, pc_d<=pc_f, pc_plus4_d<=pc_f+4, valid_d<=1.
- Latency: the instruction at address A appears on instr_d one cycle after pc_f=A, in the cycle where pc_f=A+4 (absent stall or redirect). The first instruction after reset release is captured at the first rising edge.
- Redirect penalty: the instruction fetched in the redirect cycle is discarded. The target instruction reaches instr_d two edges after pc_src is sampled.
- misaligned: set on any edge where pc_src=1 and pc_target[1:0]!=0. Sticky until reset. Fetch continues from the aligned-down target.
- Stall held for N cycles: pc_f and IF/ID are frozen for exactly N edges. im_address stays constant during the stall.
- Simultaneous stall and pc_src: pc_src wins for both PC and IF/ID (bubble inserted, PC redirected).

Test Plan:
- Reset then run 4 cycles, IM[0..3]=0x01234567,0x01234568,0x01234569,0x0000006F -> pc_f 0,4,8,C,10. instr_d shows NOP (valid_d=0), then 0x01234567 with pc_d=0, then 0x01234568 with pc_d=4, then 0x01234569 with pc_d=8. pc_plus4_d=pc_d+4.
- Stall asserted 3 cycles while pc_f=8 -> pc_f stays 8, instr_d stays 0x01234568 for 3 edges. Resumes with 0x01234569 after deassert.
- pc_src=1, pc_target=0x40 while pc_f=0xC -> next edge: pc_f=0x40, instr_d=NOP, valid_d=0. Following edge: instr_d=IM[16], pc_d=0x40.
- pc_src and stall both 1, pc_target=0x20 -> pc_f=0x20, valid_d=0 (redirect wins). pc_target=0x22 -> pc_f=0x20, misaligned=1, flag stays 1 until reset.
- Run from 0x78 -> im_address 30, 31, then 0 at pc_f=0x80. instr_d=IM[0] with pc_d=0x80.
- Assert reset asynchronously between edges mid-run -> pc_f=0, valid_d=0, misaligned=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/instr_fetch.sv
// Fetch stage: program counter, instruction-memory word address and IF/ID register.
// Supports stall, redirect with a flush bubble, and a sticky misaligned-target flag.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned IM_ADDR_W = 5,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 pc_src,
    input  logic [31:0]          pc_target,
    output logic [IM_ADDR_W-1:0] im_address,
    input  logic [31:0]          im_rd,
    output logic [31:0]          pc_f,
    output logic [31:0]          instr_d,
    output logic [31:0]          pc_d,
    output logic [31:0]          pc_plus4_d,
    output logic                 valid_d,
    output logic                 misaligned
);

    logic [31:0] r_pc;
    logic [31:0] r_instr_d;
    logic [31:0] r_pc_d;
    logic [31:0] r_pc_plus4_d;
    logic        r_valid_d;
    logic        r_misaligned;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_target_aligned;

    assign w_pc_plus4       = r_pc + 32'd4;
    assign w_target_aligned = {pc_target[31:2], 2'b00};

    // Redirect takes priority over stall for both the PC and the IF/ID register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (pc_src) begin
            r_pc <= w_target_aligned;
        end else if (!stall) begin
            r_pc <= w_pc_plus4;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr_d    <= NOP_INSTR;
            r_pc_d       <= '0;
            r_pc_plus4_d <= '0;
            r_valid_d    <= 1'b0;
        end else if (pc_src) begin
            r_instr_d    <= NOP_INSTR;
            r_pc_d       <= '0;
            r_pc_plus4_d <= '0;
            r_valid_d    <= 1'b0;
        end else if (!stall) begin
            r_instr_d    <= im_rd;
            r_pc_d       <= r_pc;
            r_pc_plus4_d <= w_pc_plus4;
            r_valid_d    <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_misaligned <= 1'b0;
        end else if (pc_src && (pc_target[1:0] != 2'b00)) begin
            r_misaligned <= 1'b1;
        end
    end

    assign im_address = r_pc[IM_ADDR_W+1:2];
    assign pc_f       = r_pc;
    assign instr_d    = r_instr_d;
    assign pc_d       = r_pc_d;
    assign pc_plus4_d = r_pc_plus4_d;
    assign valid_d    = r_valid_d;
    assign misaligned = r_misaligned;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a behavioural 32-word instruction memory.
module tb_instr_fetch;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        pc_src;
    logic [31:0] pc_target;
    logic [4:0]  im_address;
    logic [31:0] im_rd;
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic        valid_d;
    logic        misaligned;

    logic [31:0] im [32];
    int unsigned n_total;
    int unsigned n_pass;
    int unsigned n_fail;

    localparam logic [31:0] NOP = 32'h0000_0013;

    instr_fetch #(
        .RESET_PC (32'h0000_0000),
        .IM_ADDR_W(5),
        .NOP_INSTR(NOP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .pc_src    (pc_src),
        .pc_target (pc_target),
        .im_address(im_address),
        .im_rd     (im_rd),
        .pc_f      (pc_f),
        .instr_d   (instr_d),
        .pc_d      (pc_d),
        .pc_plus4_d(pc_plus4_d),
        .valid_d   (valid_d),
        .misaligned(misaligned)
    );

    assign im_rd = im[im_address];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                            input logic [31:0] e_pcd, input logic e_valid);
        chk({tag, ".pc_f"}, pc_f, e_pc);
        chk({tag, ".instr_d"}, instr_d, e_instr);
        chk({tag, ".pc_d"}, pc_d, e_pcd);
        chk({tag, ".pc_plus4_d"}, pc_plus4_d, e_valid ? e_pcd + 32'd4 : 32'd0);
        chk({tag, ".valid_d"}, {31'd0, valid_d}, {31'd0, e_valid});
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        n_fail  = 0;
        for (int i = 0; i < 32; i++) im[i] = 32'hA500_0000 | i;
        im[0] = 32'h0123_4567;
        im[1] = 32'h0123_4568;
        im[2] = 32'h0123_4569;
        im[3] = 32'h0000_006F;

        reset     = 1'b1;
        stall     = 1'b0;
        pc_src    = 1'b0;
        pc_target = 32'h0;
        #2;
        chk_ifid("reset", 32'h0, NOP, 32'h0, 1'b0);
        chk("reset.misaligned", {31'd0, misaligned}, 32'd0);
        chk("reset.im_address", {27'd0, im_address}, 32'd0);
        reset = 1'b0;

        step(); chk_ifid("run1", 32'h4, 32'h0123_4567, 32'h0, 1'b1);
        step(); chk_ifid("run2", 32'h8, 32'h0123_4568, 32'h4, 1'b1);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_ifid("stall", 32'h8, 32'h0123_4568, 32'h4, 1'b1);
            chk("stall.im_address", {27'd0, im_address}, 32'd2);
        end
        stall = 1'b0;
        step(); chk_ifid("resume", 32'hC, 32'h0123_4569, 32'h8, 1'b1);

        pc_src = 1'b1; pc_target = 32'h40;
        step(); chk_ifid("redir", 32'h40, NOP, 32'h0, 1'b0);
        pc_src = 1'b0;
        step(); chk_ifid("redir_tgt", 32'h44, im[16], 32'h40, 1'b1);

        pc_src = 1'b1; stall = 1'b1; pc_target = 32'h20;
        step(); chk_ifid("redir_stall", 32'h20, NOP, 32'h0, 1'b0);
        chk("redir_stall.misaligned", {31'd0, misaligned}, 32'd0);
        stall = 1'b0; pc_target = 32'h22;
        step(); chk_ifid("misal", 32'h20, NOP, 32'h0, 1'b0);
        chk("misal.flag", {31'd0, misaligned}, 32'd1);
        pc_src = 1'b0;
        step(); chk_ifid("misal_run", 32'h24, im[8], 32'h20, 1'b1);
        chk("misal.sticky", {31'd0, misaligned}, 32'd1);

        pc_src = 1'b1; pc_target = 32'h78;
        step(); chk("wrap.addr30", {27'd0, im_address}, 32'd30);
        pc_src = 1'b0;
        step(); chk("wrap.addr31", {27'd0, im_address}, 32'd31);
        chk_ifid("wrap1", 32'h7C, im[30], 32'h78, 1'b1);
        step(); chk("wrap.addr0", {27'd0, im_address}, 32'd0);
        chk_ifid("wrap2", 32'h80, im[31], 32'h7C, 1'b1);
        step(); chk_ifid("wrap3", 32'h84, im[0], 32'h80, 1'b1);
        chk("wrap.sticky", {31'd0, misaligned}, 32'd1);

        // Asynchronous reset between edges: effect must be visible before the next posedge.
        #3 reset = 1'b1;
        #1;
        chk_ifid("async_rst", 32'h0, NOP, 32'h0, 1'b0);
        chk("async_rst.misaligned", {31'd0, misaligned}, 32'd0);
        #1 reset = 1'b0;

        pc_src = 1'b1; pc_target = 32'hFFFF_FFFC;
        step(); chk("pcwrap.pc_f", pc_f, 32'hFFFF_FFFC);
        pc_src = 1'b0;
        step(); chk("pcwrap.pc_f0", pc_f, 32'h0);
        chk("pcwrap.pc_d", pc_d, 32'hFFFF_FFFC);
        chk("pcwrap.pc_plus4_d", pc_plus4_d, 32'h0);
        chk("pcwrap.instr_d", instr_d, im[31]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
